// File: rtl/guess_entry.sv
// Guess entry and attempt tracking for the code-check initiator.
// Assembles a four-digit hex guess, sends it, and scores the comparator's reply.
module guess_entry #(
  parameter int unsigned MAX_ATTEMPTS   = 8,
  parameter int unsigned RESULT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        backspace,
  input  logic        submit,
  input  logic [2:0]  num_correct,
  input  logic        correct,
  input  logic        result_valid,
  output logic [15:0] my_input,
  output logic        send,
  output logic [2:0]  digit_count,
  output logic [3:0]  attempts_left,
  output logic [2:0]  last_score,
  output logic        busy,
  output logic        timeout_err,
  output logic        defused,
  output logic        exploded
);

  localparam int unsigned GW  = 16;
  localparam int unsigned CW  = 3;
  localparam int unsigned AW  = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned WCW = 8;

  typedef enum logic [2:0] {
    S_ENTRY,
    S_SEND,
    S_WAIT,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   guess_q, guess_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   attempts_q, attempts_d;
  logic [SW-1:0]   score_q, score_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            send_q, send_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            defused_q, defused_d;
  logic            exploded_q, exploded_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ENTRY;
      guess_q    <= '0;
      count_q    <= '0;
      attempts_q <= AW'(MAX_ATTEMPTS);
      score_q    <= '0;
      wait_cnt_q <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      defused_q  <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      count_q    <= count_d;
      attempts_q <= attempts_d;
      score_q    <= score_d;
      wait_cnt_q <= wait_cnt_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      defused_q  <= defused_d;
      exploded_q <= exploded_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    count_d    = count_q;
    attempts_d = attempts_q;
    score_d    = score_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;

    case (state_q)
      S_ENTRY: begin
        // submit beats backspace beats digit; a backspace on an empty guess still eats the digit
        if (submit && count_q == CW'(4)) begin
          state_d = S_SEND;
        end else if (backspace) begin
          if (count_q != '0) begin
            guess_d = {4'h0, guess_q[15:4]};
            count_d = count_q - CW'(1);
          end
        end else if (digit_valid && count_q != CW'(4)) begin
          guess_d = {guess_q[11:0], digit_in};
          count_d = count_q + CW'(1);
        end
      end
      S_SEND: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (result_valid) begin
          score_d    = num_correct;
          attempts_d = attempts_q - AW'(1);
          if (correct || num_correct == SW'(4)) begin
            state_d = S_DEFUSED;
          end else if (attempts_q == AW'(1)) begin
            state_d = S_EXPLODED;
          end else begin
            state_d = S_ENTRY;
            guess_d = '0;
            count_d = '0;
          end
        end else if (wait_cnt_q == WCW'(RESULT_TIMEOUT - 1)) begin
          state_d   = S_ENTRY;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_DEFUSED, S_EXPLODED: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_ENTRY;
      end
    endcase

    send_d     = (state_d == S_SEND);
    busy_d     = (state_d == S_SEND) || (state_d == S_WAIT);
    defused_d  = (state_d == S_DEFUSED);
    exploded_d = (state_d == S_EXPLODED);
  end

  assign my_input      = guess_q;
  assign send          = send_q;
  assign digit_count   = count_q;
  assign attempts_left = attempts_q;
  assign last_score    = score_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_q;
  assign defused       = defused_q;
  assign exploded      = exploded_q;

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboard bench for guess_entry: two parameterisations share stimulus,
// each checked every cycle against a behavioural model of the game.
module tb_guess_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_valid, backspace, submit;
  logic [2:0]  num_correct;
  logic        correct, result_valid;

  typedef struct packed {
    logic [15:0] my_input;
    logic        send;
    logic [2:0]  cnt;
    logic [3:0]  att;
    logic [2:0]  score;
    logic        busy;
    logic        tmo;
    logic        def;
    logic        expl;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  obs_t act [2];
  logic [15:0] mi0, mi1;
  logic s0, s1, b0, b1, t0, t1, d0, d1, e0, e1;
  logic [2:0] c0, c1, sc0, sc1;
  logic [3:0] a0, a1;

  guess_entry u_dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .backspace(backspace), .submit(submit), .num_correct(num_correct),
    .correct(correct), .result_valid(result_valid), .my_input(mi0), .send(s0),
    .digit_count(c0), .attempts_left(a0), .last_score(sc0), .busy(b0),
    .timeout_err(t0), .defused(d0), .exploded(e0)
  );

  guess_entry #(.MAX_ATTEMPTS(2), .RESULT_TIMEOUT(3)) u_dut2 (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .backspace(backspace), .submit(submit), .num_correct(num_correct),
    .correct(correct), .result_valid(result_valid), .my_input(mi1), .send(s1),
    .digit_count(c1), .attempts_left(a1), .last_score(sc1), .busy(b1),
    .timeout_err(t1), .defused(d1), .exploded(e1)
  );

  always #5 clk = ~clk;

  assign act[0] = '{mi0, s0, c0, a0, sc0, b0, t0, d0, e0};
  assign act[1] = '{mi1, s1, c1, a1, sc1, b1, t1, d1, e1};

  // Behavioural game model, one slot per DUT
  int          m_max [2] = '{8, 2};
  int          m_tmo [2] = '{15, 3};
  int          m_guess [2] = '{0, 0};
  int          m_cnt [2] = '{0, 0};
  int          m_att [2] = '{0, 0};
  int          m_score [2] = '{0, 0};
  int          m_waited [2] = '{0, 0};
  bit          m_sending [2], m_waiting [2], m_won [2], m_lost [2];
  bit          m_send_o [2], m_tmo_o [2];

  pair_t exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.my_input = 16'(m_guess[i]);
    o.send     = m_send_o[i];
    o.cnt      = 3'(m_cnt[i]);
    o.att      = 4'(m_att[i]);
    o.score    = 3'(m_score[i]);
    o.busy     = m_sending[i] || m_waiting[i];
    o.tmo      = m_tmo_o[i];
    o.def      = m_won[i];
    o.expl     = m_lost[i];
    return o;
  endfunction

  task automatic mstep(int i);
    m_send_o[i] = 1'b0;
    m_tmo_o[i]  = 1'b0;
    if (rst) begin
      m_guess[i] = 0; m_cnt[i] = 0; m_att[i] = m_max[i]; m_score[i] = 0;
      m_sending[i] = 0; m_waiting[i] = 0; m_won[i] = 0; m_lost[i] = 0; m_waited[i] = 0;
    end else if (m_won[i] || m_lost[i]) begin
      m_guess[i] = m_guess[i];
    end else if (m_sending[i]) begin
      m_sending[i] = 0; m_waiting[i] = 1; m_waited[i] = 0;
    end else if (m_waiting[i]) begin
      m_waited[i]++;
      if (result_valid) begin
        m_waiting[i] = 0;
        m_score[i] = int'(num_correct);
        m_att[i]--;
        if (correct || num_correct == 3'd4) m_won[i] = 1;
        else if (m_att[i] == 0) m_lost[i] = 1;
        else begin m_guess[i] = 0; m_cnt[i] = 0; end
      end else if (m_waited[i] == m_tmo[i]) begin
        m_waiting[i] = 0; m_tmo_o[i] = 1;
      end
    end else begin
      if (submit && m_cnt[i] == 4) begin
        m_sending[i] = 1; m_send_o[i] = 1;
      end else if (backspace) begin
        if (m_cnt[i] > 0) begin m_guess[i] = m_guess[i] / 16; m_cnt[i]--; end
      end else if (digit_valid && m_cnt[i] < 4) begin
        m_guess[i] = (m_guess[i] * 16 + int'(digit_in)) % 65536; m_cnt[i]++;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the expected post-edge outputs
  task automatic cyc(bit r, bit dv, logic [3:0] d, bit bs, bit sub,
                     bit rv, logic [2:0] nc, bit cor);
    pair_t p;
    @(negedge clk);
    rst = r; digit_valid = dv; digit_in = d; backspace = bs; submit = sub;
    result_valid = rv; num_correct = nc; correct = cor;
    mstep(0);
    mstep(1);
    p.a = model_obs(0);
    p.b = model_obs(1);
    exp_q.push_back(p);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 4'h0, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic dig(logic [3:0] d);
    cyc(0, 1, d, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic sub();
    cyc(0, 0, 4'h0, 0, 1, 0, 3'd0, 0);
  endtask

  task automatic score(logic [2:0] nc, bit cor);
    cyc(0, 0, 4'h0, 0, 0, 1, nc, cor);
  endtask

  task automatic guess4(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    dig(a); dig(b); dig(c); dig(d);
  endtask

  // Monitor: compare every cycle, one entry per DUT
  initial begin
    pair_t e;
    obs_t  x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          x = (i == 0) ? e.a : e.b;
          n_checks++;
          if (act[i] !== x) begin
            n_fail++;
            $display("FAIL outputs dut%0d t=%0t: got in=%h snd=%b cnt=%0d att=%0d sc=%0d bsy=%b to=%b def=%b exp=%b, want in=%h snd=%b cnt=%0d att=%0d sc=%0d bsy=%b to=%b def=%b exp=%b",
                     i, $time, act[i].my_input, act[i].send, act[i].cnt, act[i].att, act[i].score,
                     act[i].busy, act[i].tmo, act[i].def, act[i].expl,
                     x.my_input, x.send, x.cnt, x.att, x.score, x.busy, x.tmo, x.def, x.expl);
          end
        end
      end
    end
  end

  initial begin
    rst = 1; digit_valid = 0; digit_in = 0; backspace = 0; submit = 0;
    result_valid = 0; num_correct = 0; correct = 0;

    cyc(1, 0, 4'h0, 0, 0, 0, 3'd0, 0);
    cyc(1, 1, 4'h5, 0, 1, 1, 3'd4, 1);

    // Basic entry, submit, result in SEND ignored, non-winning score
    guess4(4'h1, 4'h2, 4'h3, 4'h4);
    sub();
    score(3'd4, 1);
    score(3'd2, 0);
    idle(2);

    // Editing, short submit, fifth digit, submit+digit together
    dig(4'h1); dig(4'h2); dig(4'h3);
    cyc(0, 0, 4'h0, 1, 0, 0, 3'd0, 0);
    dig(4'h9);
    cyc(0, 1, 4'h7, 0, 1, 0, 3'd0, 0);
    dig(4'h8);
    dig(4'h7);
    cyc(0, 1, 4'h6, 0, 1, 0, 3'd0, 0);
    idle(17);
    sub();
    idle(15);
    score(3'd1, 0);
    idle(2);

    // Backspace on empty with digit, then a win
    cyc(0, 1, 4'h3, 1, 0, 0, 3'd0, 0);
    guess4(4'hA, 4'hB, 4'hC, 4'hD);
    sub();
    idle(1);
    score(3'd4, 0);
    guess4(4'h1, 4'h1, 4'h1, 4'h1);
    sub();
    score(3'd0, 0);
    idle(3);

    // Reset mid-WAIT discards the pending result
    cyc(1, 0, 4'h0, 0, 0, 0, 3'd0, 0);
    guess4(4'hF, 4'hE, 4'hD, 4'hC);
    sub();
    idle(2);
    cyc(1, 0, 4'h0, 0, 0, 1, 3'd3, 0);
    score(3'd3, 0);
    idle(1);

    // Two losses explode the two-attempt unit; high scores do not win
    guess4(4'h2, 4'h4, 4'h6, 4'h8);
    sub(); idle(1); score(3'd6, 0);
    guess4(4'h3, 4'h5, 4'h7, 4'h9);
    sub(); idle(1); score(3'd7, 0);
    dig(4'h1); sub(); idle(2);

    // correct flag alone wins
    cyc(1, 0, 4'h0, 0, 0, 0, 3'd0, 0);
    guess4(4'h0, 4'h0, 4'h0, 4'h1);
    sub(); idle(1); score(3'd3, 1);
    idle(2);

    // Randomised play with rare resets
    cyc(1, 0, 4'h0, 0, 0, 0, 3'd0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit r, dv, bs, sb, rv, cor;
      r   = ($urandom_range(0, 199) == 0);
      dv  = ($urandom_range(0, 99) < 45);
      bs  = ($urandom_range(0, 99) < 8);
      sb  = ($urandom_range(0, 99) < 20);
      rv  = ($urandom_range(0, 99) < (m_waiting[0] ? 25 : 5));
      cor = ($urandom_range(0, 99) < 5);
      cyc(r, dv, 4'($urandom_range(0, 15)), bs, sb, rv, 3'($urandom_range(0, 7)), cor);
    end

    idle(1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Initiator side of the code-check interface: collects a four-digit guess one hex digit at a time from the player controls and presents it on `my_input` with a one-cycle `send` strobe. It then waits for the comparator's score and tracks the remaining attempts. It declares the game defused or exploded, and feeds the score back to the display logic. It sits between the debounced keypad/button logic and the digit comparator.

## Interface
Parameters:
- `MAX_ATTEMPTS`, default 8: guesses allowed per game; legal range 1..15.
- `RESULT_TIMEOUT`, default 15: maximum WAIT cycles before the guess is abandoned; legal range 1..255.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digit_in`  in  4  digit value, qualified by `digit_valid`.
- `digit_valid`  in  1  one-cycle strobe: append `digit_in`.
- `backspace`  in  1  one-cycle strobe: remove the last entered digit.
- `submit`  in  1  one-cycle strobe: send the guess.
- `num_correct`  in  3  score from the comparator, qualified by `result_valid`.
- `correct`  in  1  comparator full-match flag, qualified by `result_valid`.
- `result_valid`  in  1  one-cycle strobe: score is valid.
- `my_input`  out  16  assembled guess; first digit entered in [15:12], last in [3:0].
- `send`  out  1  one-cycle request to the comparator.
- `digit_count`  out  3  number of digits entered, 0..4.
- `attempts_left`  out  4  remaining guesses.
- `last_score`  out  3  `num_correct` from the most recent scored guess.
- `busy`  out  1  high in SEND or WAIT.
- `timeout_err`  out  1  one-cycle pulse when WAIT expires.
- `defused`  out  1  sticky game won.
- `exploded`  out  1  sticky game lost.

## Operation
- Reset values: `my_input`=0, `digit_count`=0, `attempts_left`=`MAX_ATTEMPTS`, `last_score`=0, `send`=0, `busy`=0, `timeout_err`=0, `defused`=0, `exploded`=0; state ENTRY. Reset applies from any state, including mid-WAIT, and discards any pending result.
- The state machine has five states: ENTRY, SEND, WAIT, DEFUSED, EXPLODED. All outputs are registered.
- ENTRY input priority per cycle is submit, then backspace, then digit. Only the highest-priority applicable action takes effect.
  - `submit` with `digit_count`==4: go to SEND. A `digit_valid` or `backspace` in the same cycle is dropped.
  - `submit` with `digit_count`<4: ignored, and the lower-priority actions are evaluated.
  - `backspace` with count>0: `my_input` <= {4'h0, `my_input`[15:4]}, count-1. With count==0: no effect, and a same-cycle digit is still dropped.
  - `digit_valid` with count<4: `my_input` <= {`my_input`[11:0], `digit_in`}, count+1. With count==4: ignored, and the guess is unchanged.
- SEND: `send`=1 for exactly this cycle. `my_input` is frozen. Next state is WAIT, and the timeout counter clears.
- WAIT: `my_input` is frozen and all player strobes are ignored. `result_valid` is sampled only in WAIT; a `result_valid` in SEND is ignored.
  - On `result_valid`, `last_score` <= `num_correct` and `attempts_left` is decremented.
  - If `correct`==1 or `num_correct`==4: go to DEFUSED.
  - Otherwise, if `attempts_left` was 1: go to EXPLODED.
  - Otherwise: go to ENTRY with `my_input`=0 and count=0.
  - Scores 5..7 are stored as received and treated as non-winning.
- Timeout: after `RESULT_TIMEOUT` WAIT cycles with no `result_valid`, pulse `timeout_err` and return to ENTRY. The guess is kept (count=4) and `attempts_left` is unchanged, so the player may resubmit. A `result_valid` on the final WAIT cycle takes priority over the timeout.
- DEFUSED and EXPLODED are terminal until `rst`. The corresponding flag is held at 1, `my_input` holds the last guess, and all inputs are ignored.

## Timing
- Digit and backspace edits are visible on `my_input` and `digit_count` one cycle after the strobe.
- A `submit` accepted in cycle N gives `send`=1 in cycle N+1 and `busy`=1 from N+1.
- A `result_valid` in WAIT cycle M updates `last_score`, `attempts_left` and the state outputs at M+1. The earliest possible M is N+2.
- The timeout fires if WAIT is entered at N+2 and no result arrives through cycle N+1+`RESULT_TIMEOUT`. In that case `timeout_err`=1 and `busy`=0 at N+2+`RESULT_TIMEOUT`.
- The earliest next `send` after a scored guess requires four new digits plus a submit, so there is a minimum of 5 ENTRY cycles between sends.

## Test plan
- Enter 1,2,3,4, then `submit` -> `my_input`=16'h1234, `digit_count`=4, and exactly one `send` pulse on the cycle after submit.
- Enter 1,2,3, then backspace, then 9,8 -> `my_input`=16'h1298. Submit with 3 digits produces no `send`. A fifth digit leaves the guess unchanged.
- From reset, score 2 with `correct`=0 -> `last_score`=2, `attempts_left`=7, state ENTRY, `my_input`=0. Then score 4 -> `defused`=1, `attempts_left`=6, and further strobes produce no effect.
- With `MAX_ATTEMPTS`=2, return two non-winning scores -> `exploded`=1 and `attempts_left`=0. Later `submit` produces no `send`.
- With no `result_valid` for `RESULT_TIMEOUT`=15 WAIT cycles -> `timeout_err` pulses once, `attempts_left` is unchanged, and the guess is retained. A resubmit produces `send` again. Repeat with `result_valid` on WAIT cycle 15 -> the result is scored and no timeout fires.
- Assert `rst` mid-WAIT, then `result_valid` -> all outputs are at reset values and the result is ignored. Also check a simultaneous `submit`+`digit_valid` at count 4 -> `send` is issued and the digit is dropped.
